// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: fetch FSM states, IF/ID load select,
// reset/bubble defaults and the primary opcode field values.
package mips_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    MISS = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    IFID_HOLD   = 2'd0,
    IFID_LOAD   = 2'd1,
    IFID_BUBBLE = 2'd2
  } ifid_sel_e;

  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                              input logic [31:0] instr);
    return {pc4[31:28], instr[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads a fetched word, holds it, or inserts a bubble.
module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  ifid_sel_e   sel,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc4_in,
  output logic [31:0] instr,
  output logic [31:0] pc4,
  output logic        valid
);

  logic [31:0] r_instr;
  logic [31:0] r_pc4;
  logic        r_valid;

  // IF/ID register update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr <= NOP_INSTR;
      r_pc4   <= 32'h0000_0000;
      r_valid <= 1'b0;
    end else begin
      case (sel)
        IFID_LOAD: begin
          r_instr <= instr_in;
          r_pc4   <= pc4_in;
          r_valid <= 1'b1;
        end
        IFID_HOLD: begin
          r_instr <= r_instr;
          r_pc4   <= r_pc4;
          r_valid <= r_valid;
        end
        IFID_BUBBLE: begin
          r_instr <= NOP_INSTR;
          r_pc4   <= 32'h0000_0000;
          r_valid <= 1'b0;
        end
        default: begin
          r_instr <= NOP_INSTR;
          r_pc4   <= 32'h0000_0000;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign instr = r_instr;
  assign pc4   = r_pc4;
  assign valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, fetch FSM (BOOT/RUN/MISS), redirects and stalls,
// feeding the IF/ID register.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        id_jump,
  input  logic        ex_branch_taken,
  input  logic [31:0] ex_branch_target,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [31:0] fetch_count
);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_nxt;
  logic [31:0]  w_pc4;
  logic [31:0]  r_fetch_count;
  logic         r_imem_req;
  logic         w_count_inc;
  ifid_sel_e    w_ifid_sel;
  logic [31:0]  w_if_id_instr;
  logic [31:0]  w_if_id_pc4;
  logic         w_if_id_valid;
  logic         w_unused_tgt_lsb;

  // Branch targets are forced word-aligned, so the low bits are dropped
  assign w_unused_tgt_lsb = ^ex_branch_target[1:0];
  assign w_pc4            = r_pc + 32'd4;

  // Next-state, next-PC and IF/ID select in redirect/stall/miss priority order
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ifid_sel  = IFID_HOLD;
    w_count_inc = 1'b0;
    case (r_state)
      BOOT: begin
        w_ifid_sel  = IFID_BUBBLE;
        w_state_nxt = RUN;
      end
      RUN, MISS: begin
        if (ex_branch_taken) begin
          w_pc_nxt    = {ex_branch_target[31:2], 2'b00};
          w_ifid_sel  = IFID_BUBBLE;
          w_state_nxt = RUN;
        end else if (stall) begin
          w_pc_nxt    = r_pc;
          w_ifid_sel  = IFID_HOLD;
          w_state_nxt = r_state;
        end else if (id_jump) begin
          w_pc_nxt    = jump_target(w_if_id_pc4, w_if_id_instr);
          w_ifid_sel  = IFID_BUBBLE;
          w_state_nxt = RUN;
        end else if (!imem_ready) begin
          w_pc_nxt    = r_pc;
          w_ifid_sel  = IFID_BUBBLE;
          w_state_nxt = MISS;
        end else begin
          w_pc_nxt    = w_pc4;
          w_ifid_sel  = IFID_LOAD;
          w_count_inc = 1'b1;
          w_state_nxt = RUN;
        end
      end
      default: begin
        w_ifid_sel  = IFID_BUBBLE;
        w_state_nxt = BOOT;
      end
    endcase
  end

  // State, PC, request and fetch counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= BOOT;
      r_pc          <= RESET_PC;
      r_fetch_count <= 32'h0000_0000;
      r_imem_req    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_imem_req <= (w_state_nxt != BOOT);
      if (w_count_inc) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end else begin
        r_fetch_count <= r_fetch_count;
      end
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .sel      (w_ifid_sel),
    .instr_in (imem_rdata),
    .pc4_in   (w_pc4),
    .instr    (w_if_id_instr),
    .pc4      (w_if_id_pc4),
    .valid    (w_if_id_valid)
  );

  assign imem_addr   = r_pc;
  assign imem_req    = r_imem_req;
  assign if_id_instr = w_if_id_instr;
  assign if_id_pc4   = w_if_id_pc4;
  assign if_id_valid = w_if_id_valid;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a combinational
// instruction memory model.
module tb_fetch_stage;
  import mips_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        stall;
  logic        id_jump;
  logic        ex_branch_taken;
  logic [31:0] ex_branch_target;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [31:0] fetch_count;

  int n_checks;
  int n_fail;

  fetch_stage dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_addr        (imem_addr),
    .imem_req         (imem_req),
    .imem_rdata       (imem_rdata),
    .imem_ready       (imem_ready),
    .stall            (stall),
    .id_jump          (id_jump),
    .ex_branch_taken  (ex_branch_taken),
    .ex_branch_target (ex_branch_target),
    .if_id_instr      (if_id_instr),
    .if_id_pc4        (if_id_pc4),
    .if_id_valid      (if_id_valid),
    .fetch_count      (fetch_count)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h2001_0005;
    else if (a == 32'h1000_000C) return 32'h0800_0040;
    else return {8'hC0, a[23:0]};
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] instr,
                            input logic [31:0] pc4, input logic valid);
    check_eq({tag, "_instr"}, if_id_instr, instr);
    check_eq({tag, "_pc4"}, if_id_pc4, pc4);
    check_eq({tag, "_valid"}, {31'd0, if_id_valid}, {31'd0, valid});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b1; imem_ready = 1'b1; stall = 1'b0; id_jump = 1'b0;
    ex_branch_taken = 1'b0; ex_branch_target = 32'h0;
    #2 rst_n = 1'b0;
    step(); step();
    check_eq("rst_addr", imem_addr, 32'h0);
    check_eq("rst_req", {31'd0, imem_req}, 32'd0);
    check_ifid("rst", 32'h0, 32'h0, 1'b0);
    check_eq("rst_cnt", fetch_count, 32'd0);
    rst_n = 1'b1;

    // BOOT cycle, then first real fetch
    step();
    check_ifid("boot", 32'h0, 32'h0, 1'b0);
    check_eq("boot_req", {31'd0, imem_req}, 32'd1);
    check_eq("boot_addr", imem_addr, 32'h0);
    step();
    check_ifid("f0", 32'h2001_0005, 32'h4, 1'b1);
    check_eq("f0_cnt", fetch_count, 32'd1);
    check_eq("f0_addr", imem_addr, 32'h4);
    step();
    check_ifid("f1", 32'hC000_0004, 32'h8, 1'b1);
    check_eq("f1_addr", imem_addr, 32'h8);
    check_eq("f1_cnt", fetch_count, 32'd2);

    // Memory wait for 3 cycles at pc=8
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_ifid("miss", 32'h0, 32'h0, 1'b0);
      check_eq("miss_addr", imem_addr, 32'h8);
      check_eq("miss_cnt", fetch_count, 32'd2);
    end
    imem_ready = 1'b1;
    step();
    check_ifid("miss_done", 32'hC000_0008, 32'hC, 1'b1);
    check_eq("miss_done_cnt", fetch_count, 32'd3);
    check_eq("miss_done_addr", imem_addr, 32'hC);

    // PC wrap from 0xFFFF_FFFC to 0
    ex_branch_taken = 1'b1; ex_branch_target = 32'hFFFF_FFFF;
    step();
    ex_branch_taken = 1'b0;
    check_eq("wrap_br_addr", imem_addr, 32'hFFFF_FFFC);
    check_ifid("wrap_br", 32'h0, 32'h0, 1'b0);
    step();
    check_ifid("wrap", 32'hC0FF_FFFC, 32'h0, 1'b1);
    check_eq("wrap_addr", imem_addr, 32'h0);
    check_eq("wrap_cnt", fetch_count, 32'd4);

    // Reach the j instruction at 0x1000_000C
    ex_branch_taken = 1'b1; ex_branch_target = 32'h1000_000C;
    step();
    ex_branch_taken = 1'b0;
    check_eq("tojmp_addr", imem_addr, 32'h1000_000C);
    step();
    check_ifid("jword", 32'h0800_0040, 32'h1000_0010, 1'b1);
    check_eq("jword_cnt", fetch_count, 32'd5);

    // Stall with jump pending: everything frozen; second cycle also has a miss
    stall = 1'b1; id_jump = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (i == 1) imem_ready = 1'b0;
      step();
      check_eq("stall_addr", imem_addr, 32'h1000_0010);
      check_ifid("stall", 32'h0800_0040, 32'h1000_0010, 1'b1);
      check_eq("stall_cnt", fetch_count, 32'd5);
    end
    stall = 1'b0; imem_ready = 1'b1;
    step();
    id_jump = 1'b0;
    check_eq("jump_addr", imem_addr, 32'h1000_0100);
    check_ifid("jump_bub", 32'h0, 32'h0, 1'b0);
    check_eq("jump_cnt", fetch_count, 32'd5);
    step();
    check_ifid("post_jump", 32'hC000_0100, 32'h1000_0104, 1'b1);
    check_eq("post_jump_cnt", fetch_count, 32'd6);

    // Branch beats stall and jump, even from MISS
    imem_ready = 1'b0;
    step();
    check_eq("pre_br_state", 32'(dut.r_state), 32'(MISS));
    ex_branch_taken = 1'b1; ex_branch_target = 32'h0000_0203;
    stall = 1'b1; id_jump = 1'b1;
    step();
    ex_branch_taken = 1'b0; stall = 1'b0; id_jump = 1'b0; imem_ready = 1'b1;
    check_eq("br_addr", imem_addr, 32'h0000_0200);
    check_ifid("br", 32'h0, 32'h0, 1'b0);
    check_eq("br_state", 32'(dut.r_state), 32'(RUN));
    check_eq("br_cnt", fetch_count, 32'd6);
    step();
    check_ifid("post_br", 32'hC000_0200, 32'h204, 1'b1);
    check_eq("post_br_cnt", fetch_count, 32'd7);

    // Asynchronous reset in the middle of a miss
    imem_ready = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_addr", imem_addr, 32'h0);
    check_eq("arst_req", {31'd0, imem_req}, 32'd0);
    check_ifid("arst", 32'h0, 32'h0, 1'b0);
    check_eq("arst_cnt", fetch_count, 32'd0);
    check_eq("arst_state", 32'(dut.r_state), 32'(BOOT));
    step();
    rst_n = 1'b1; imem_ready = 1'b1;
    step();
    check_ifid("reboot", 32'h0, 32'h0, 1'b0);
    check_eq("reboot_req", {31'd0, imem_req}, 32'd1);
    step();
    check_ifid("refetch", 32'h2001_0005, 32'h4, 1'b1);
    check_eq("refetch_cnt", fetch_count, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the MIPS core. It owns the PC, drives the instruction-memory address, and registers the fetched word with its PC+4 for the ID stage, where `control` decodes bits [31:26]. It also applies redirects (jump from ID, taken branch from EX), load-use stalls, and memory wait cycles.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded at reset.
- `NOP_INSTR`, default 32'h0000_0000: instruction word inserted as a bubble (`sll $0,$0,0`).

Ports:
- `clk`  in  1  rising-edge clock (single clock domain).
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_addr`  out  32  fetch address; always equals `pc`.
- `imem_req`  out  1  fetch request.
- `imem_rdata`  in  32  instruction word; valid in the same cycle as `imem_ready`.
- `imem_ready`  in  1  memory has returned `imem_rdata` for `imem_addr` this cycle.
- `stall`  in  1  load-use hold from the hazard unit.
- `id_jump`  in  1  `jump` output of `control` for the instruction currently in IF/ID.
- `ex_branch_taken`  in  1  resolved taken branch (beq/bne) in EX.
- `ex_branch_target`  in  32  branch target.
- `if_id_instr`  out  32  registered instruction word to ID.
- `if_id_pc4`  out  32  registered PC+4 of that instruction.
- `if_id_valid`  out  1  IF/ID holds a real instruction (0 = bubble).
- `fetch_count`  out  32  count of instructions captured into IF/ID.

## Operation
- FSM states: BOOT, RUN, MISS.
  - BOOT is entered on reset and lasts one cycle. `imem_req`=0, IF/ID loads a bubble, and the next state is RUN.
  - In RUN and MISS, `imem_req`=1.
- Per-cycle action in RUN/MISS, in priority order (first match wins):
  1. `ex_branch_taken`: `pc`<=`{ex_branch_target[31:2],2'b00}`; IF/ID<=bubble; next state RUN. This overrides `stall` and `id_jump`.
  2. `stall`: `pc`, IF/ID, state and `fetch_count` all hold. `id_jump` is ignored.
  3. `id_jump`: `pc`<=`{if_id_pc4[31:28], if_id_instr[25:0], 2'b00}`; IF/ID<=bubble, so the word fetched this cycle is squashed; next state RUN.
  4. `imem_ready`=0: `pc` holds; IF/ID<=bubble; next state MISS.
  5. Otherwise (normal fetch): IF/ID<={`imem_rdata`, `pc`+4, valid=1}; `pc`<=`pc`+4; `fetch_count`+=1; next state RUN.
- Bubble definition: `if_id_instr`=`NOP_INSTR`, `if_id_pc4`=0, `if_id_valid`=0.
- Arithmetic:
  - `pc`+4 is 32-bit modulo; 32'hFFFF_FFFC advances to 0.
  - `fetch_count` wraps at 2^32 without saturating.
- Reset (async, any state, including mid-MISS):
  - `pc`=`RESET_PC`, state=BOOT.
  - `if_id_instr`=`NOP_INSTR`, `if_id_pc4`=0, `if_id_valid`=0.
  - `fetch_count`=0, `imem_req`=0.

## Timing
- Fetch-to-ID latency is 1 cycle: a word accepted at edge N appears on `if_id_*` after edge N.
- Throughput is 1 instruction/cycle when `imem_ready`=1 and there is no stall or redirect.
- Jump penalty: 1 bubble. Taken-branch penalty: 1 bubble in IF/ID. Flushing ID/EX is the downstream stage's job.
- `imem_addr` changes only at clock edges. In MISS it stays stable until `imem_ready` is seen or a redirect occurs.
- If `stall` and `imem_ready`=0 coincide, the stall wins: IF/ID holds and is not bubbled.
- If `ex_branch_taken` and `id_jump` coincide, the branch wins and the jump is squashed.
- The first real fetch request occurs in the cycle after reset deasserts plus one (BOOT).

## Structure
- The shared package `mips_pkg` holds:
  - the FSM state enum (BOOT/RUN/MISS);
  - `NOP_INSTR` and `RESET_PC` defaults;
  - the opcode constants (J = 6'b000010, BEQ, BNE, ...), which `control` shares.
- One sub-module, `if_id_reg`: the IF/ID register with load/hold/bubble select. PC logic and the FSM stay in `fetch_stage`.

## Test plan
- Reset, then `imem_ready`=1 with memory returning 32'h2001_0005 at address 0:
  - cycle 1 after reset: bubble;
  - next cycle: `if_id_instr`=32'h2001_0005, `if_id_pc4`=4, valid=1;
  - `fetch_count`=1;
  - `pc` advances 0 → 4 → 8.
- `imem_ready` low for 3 cycles at `pc`=8:
  - 3 bubbles, `imem_addr` held at 8;
  - the word is captured when ready returns;
  - `fetch_count` increments exactly once.
- IF/ID holds 32'h0800_0040 (j) with `if_id_pc4`=32'h1000_0010, and `id_jump`=1:
  - next `pc`=32'h1000_0100;
  - IF/ID bubbled for one cycle.
- `stall`=1 for 2 cycles together with `id_jump`=1:
  - `pc`, IF/ID and count frozen; jump ignored;
  - the jump takes effect in the first cycle after the stall drops.
- `ex_branch_taken`=1 with target 32'h0000_0203, simultaneous with `stall` and `id_jump`:
  - `pc`=32'h0000_0200, IF/ID bubbled, state RUN.
- `rst_n` pulsed low mid-MISS, asynchronously between edges:
  - all outputs take their reset values immediately;
  - `pc`=`RESET_PC`;
  - BOOT behaviour repeats.
